// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load op encodings, FSM states, byte-enable constants.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LB   = 3'd1,
    OP_LBU  = 3'd2,
    OP_LH   = 3'd3,
    OP_LHU  = 3'd4,
    OP_LW   = 3'd5,
    OP_LWL  = 3'd6,
    OP_LWR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  function automatic logic is_load(input logic [2:0] op);
    return op != OP_NONE;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment/extension and byte-enable generation for the writeback stage.
// LWL/LWR partial-word merges are built only when WB_UNALIGNED_EN is defined.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  input  logic [31:0] res,
  output logic [3:0]  we,
  output logic [31:0] wd
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata[{a, 3'b000} +: 8];
  assign lane_half = a[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    we = BE_ALL;
    wd = res;
    unique case (op_e'(op))
      OP_NONE: wd = res;
      OP_LB:   wd = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  wd = {24'h0, lane_byte};
      OP_LH:   wd = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  wd = {16'h0, lane_half};
      OP_LW:   wd = rdata;
`ifdef WB_UNALIGNED_EN
      OP_LWL: begin
        unique case (a)
          2'd0: begin we = 4'b1000; wd = rdata << 24; end
          2'd1: begin we = 4'b1100; wd = rdata << 16; end
          2'd2: begin we = 4'b1110; wd = rdata << 8;  end
          2'd3: begin we = 4'b1111; wd = rdata;       end
        endcase
      end
      OP_LWR: begin
        unique case (a)
          2'd0: begin we = 4'b1111; wd = rdata;       end
          2'd1: begin we = 4'b0111; wd = rdata >> 8;  end
          2'd2: begin we = 4'b0011; wd = rdata >> 16; end
          2'd3: begin we = 4'b0001; wd = rdata >> 24; end
        endcase
      end
`else
      OP_LWL, OP_LWR: begin
        we = BE_NONE;
        wd = '0;
      end
`endif
      default: we = BE_NONE;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, waits for load data, drives register-file byte writes,
// bypass and retired count. Define WB_UNALIGNED_EN to enable LWL/LWR partial writes.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_pc,
  input  logic [2:0]       mem_op,
  input  logic             mem_wen,
  input  logic [4:0]       mem_wr,
  input  logic [31:0]      mem_res,
  input  logic [31:0]      dm_rdata,
  input  logic             dm_data_ok,
  output logic [3:0]       reg_we,
  output logic [4:0]       reg_wr,
  output logic [31:0]      reg_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_wr,
  output logic [31:0]      fwd_wd,
  output logic             wb_busy,
  output logic [31:0]      wb_pc,
  output logic [CNT_W-1:0] retired
);

  state_e           state;
  logic [2:0]       h_op;
  logic             h_wen;
  logic [4:0]       h_wr;
  logic [31:0]      h_res;
  logic [31:0]      h_pc;
  logic [CNT_W-1:0] cnt;

  logic        commit;
  logic        capture;
  logic        wr_en;
  logic [3:0]  al_we;
  logic [31:0] al_wd;

  // A held load commits only in the cycle its data arrives; dm_data_ok is ignored elsewhere.
  assign commit    = (state == HOLD) || ((state == WAIT) && dm_data_ok);
  assign mem_ready = (state == EMPTY) || commit;
  assign capture   = mem_valid && mem_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      h_op  <= '0;
      h_wen <= 1'b0;
      h_wr  <= '0;
      h_res <= '0;
      h_pc  <= '0;
      cnt   <= '0;
    end else begin
      if (capture) begin
        state <= is_load(mem_op) ? WAIT : HOLD;
        h_op  <= mem_op;
        h_wen <= mem_wen;
        h_wr  <= mem_wr;
        h_res <= mem_res;
        h_pc  <= mem_pc;
      end else if (commit) begin
        state <= EMPTY;
      end
      if (commit) cnt <= cnt + 1'b1;
    end
  end

  wb_load_align u_align (
    .op    (h_op),
    .a     (h_res[1:0]),
    .rdata (dm_rdata),
    .res   (h_res),
    .we    (al_we),
    .wd    (al_wd)
  );

  // Writes to r0 or from non-writing instructions still retire but touch no byte lanes.
  assign wr_en     = h_wen && (h_wr != 5'd0);
  assign reg_we    = (commit && wr_en) ? al_we : BE_NONE;
  assign reg_wr    = commit ? h_wr : 5'd0;
  assign reg_wd    = commit ? al_wd : 32'd0;
  assign fwd_valid = commit && wr_en && (al_we == BE_ALL);
  assign fwd_wr    = reg_wr;
  assign fwd_wd    = reg_wd;
  assign wb_busy   = (state == WAIT);
  assign wb_pc     = h_pc;
  assign retired   = cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a one-slot behavioural model of the writeback stage.
module tb_wb_stage;

  localparam logic [2:0] NONE = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3,
                         LHU = 3'd4, LW = 3'd5, LWL = 3'd6, LWR = 3'd7;

  logic        clk, rst_n;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_pc;
  logic [2:0]  mem_op;
  logic        mem_wen;
  logic [4:0]  mem_wr;
  logic [31:0] mem_res;
  logic [31:0] dm_rdata;
  logic        dm_data_ok;
  logic [3:0]  reg_we;
  logic [4:0]  reg_wr;
  logic [31:0] reg_wd;
  logic        fwd_valid;
  logic [4:0]  fwd_wr;
  logic [31:0] fwd_wd;
  logic        wb_busy;
  logic [31:0] wb_pc;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  logic [31:0] next_pc = 32'h1000;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_op(mem_op),
    .mem_wen(mem_wen), .mem_wr(mem_wr), .mem_res(mem_res),
    .dm_rdata(dm_rdata), .dm_data_ok(dm_data_ok),
    .reg_we(reg_we), .reg_wr(reg_wr), .reg_wd(reg_wd),
    .fwd_valid(fwd_valid), .fwd_wr(fwd_wr), .fwd_wd(fwd_wd),
    .wb_busy(wb_busy), .wb_pc(wb_pc), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]  op;
    logic        wen;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] pc;
  } instr_t;

  instr_t      held;
  bit          held_v = 0;
  logic [31:0] m_cnt = 0;

  // What the register file must receive for instruction h given the memory word.
  function automatic void model_write(input instr_t h, input logic [31:0] rdata,
                                      output logic [3:0] we, output logic [31:0] wd);
    logic [7:0] b [4];
    int a, lo;
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    a  = int'(h.res[1:0]);
    lo = (a / 2) * 2;
    we = 4'hF;
    wd = h.res;
    case (h.op)
      LB:  wd = {{24{b[a][7]}}, b[a]};
      LBU: wd = {24'h0, b[a]};
      LH:  wd = {{16{b[lo+1][7]}}, b[lo+1], b[lo]};
      LHU: wd = {16'h0, b[lo+1], b[lo]};
      LW:  wd = rdata;
`ifdef WB_UNALIGNED_EN
      LWL: begin we = 4'hF << (3 - a); wd = rdata << (8 * (3 - a)); end
      LWR: begin we = 4'hF >> a;       wd = rdata >> (8 * a);       end
`else
      LWL, LWR: we = 4'h0;
`endif
      default: ;
    endcase
    if (!h.wen || h.wr == 5'd0) we = 4'h0;
  endfunction

  // Compare on the falling edge, then advance the model as the next rising edge will.
  always @(negedge clk) begin
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    bit          is_ld, commit, ready;
    if (!rst_n) begin
      check("rst_reg_we", {28'h0, reg_we}, 32'h0);
      check("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      check("rst_wb_busy", {31'h0, wb_busy}, 32'h0);
      check("rst_retired", retired, 32'h0);
      check("rst_mem_ready", {31'h0, mem_ready}, 32'h1);
      held_v = 0;
      m_cnt  = 0;
    end else begin
      is_ld  = held_v && (held.op != NONE);
      commit = held_v && (!is_ld || dm_data_ok);
      ready  = !held_v || commit;
      model_write(held, dm_rdata, e_we, e_wd);
      if (!commit) e_we = 4'h0;
      check("m_mem_ready", {31'h0, mem_ready}, {31'h0, ready});
      check("m_wb_busy", {31'h0, wb_busy}, {31'h0, is_ld});
      check("m_reg_we", {28'h0, reg_we}, {28'h0, e_we});
      check("m_fwd_valid", {31'h0, fwd_valid}, {31'h0, e_we == 4'hF});
      check("m_retired", retired, m_cnt);
      if (held_v) check("m_wb_pc", wb_pc, held.pc);
      if (e_we != 4'h0) begin
        check("m_reg_wr", {27'h0, reg_wr}, {27'h0, held.wr});
        check("m_reg_wd", reg_wd, e_wd);
      end
      if (e_we == 4'hF) begin
        check("m_fwd_wr", {27'h0, fwd_wr}, {27'h0, held.wr});
        check("m_fwd_wd", fwd_wd, e_wd);
      end
      if (commit) m_cnt = m_cnt + 1;
      if (mem_valid && ready) begin
        held   = '{op: mem_op, wen: mem_wen, wr: mem_wr, res: mem_res, pc: mem_pc};
        held_v = 1;
      end else if (commit) begin
        held_v = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic wen, input logic [4:0] wr,
                       input logic [31:0] res);
    mem_valid = 1'b1;
    mem_op    = op;
    mem_wen   = wen;
    mem_wr    = wr;
    mem_res   = res;
    mem_pc    = next_pc;
    next_pc   = next_pc + 4;
    step();
    mem_valid = 1'b0;
  endtask

  task automatic load(input string name, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] rdata, input int delay,
                      input logic [3:0] exp_we, input logic [31:0] exp_wd, input logic exp_fwd);
    dm_data_ok = 1'b0;
    dm_rdata   = 32'hDEADBEEF;
    issue(op, 1'b1, 5'd7, addr);
    for (int i = 0; i < delay; i++) begin
      check({name, "_ready_wait"}, {31'h0, mem_ready}, 32'h0);
      check({name, "_busy_wait"}, {31'h0, wb_busy}, 32'h1);
      step();
    end
    dm_rdata   = rdata;
    dm_data_ok = 1'b1;
    #1;
    check({name, "_ready"}, {31'h0, mem_ready}, 32'h1);
    check({name, "_we"}, {28'h0, reg_we}, {28'h0, exp_we});
    if (exp_we != 4'h0) check({name, "_wd"}, reg_wd, exp_wd);
    check({name, "_fwd"}, {31'h0, fwd_valid}, {31'h0, exp_fwd});
    step();
    dm_data_ok = 1'b0;
  endtask

  localparam int NB = 6;
  logic [2:0]  b_op  [NB] = '{NONE, LW, NONE, LBU, LWR, NONE};
  logic        b_wen [NB] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0]  b_wr  [NB] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd0};
  logic [31:0] b_res [NB] = '{32'hCAFE0001, 32'h2000, 32'h55, 32'h2001, 32'h2003, 32'h77};

  initial begin
    logic [31:0] r_before;
    rst_n = 1'b0; mem_valid = 1'b0; mem_pc = '0; mem_op = NONE; mem_wen = 1'b0;
    mem_wr = '0; mem_res = '0; dm_rdata = '0; dm_data_ok = 1'b0;
    step(); step();
    check("rst_reg_wr", {27'h0, reg_wr}, 32'h0);
    check("rst_reg_wd", reg_wd, 32'h0);
    check("rst_wb_pc", wb_pc, 32'h0);
    rst_n = 1'b1;
    step();

    // ALU result write
    issue(NONE, 1'b1, 5'd3, 32'h12345678);
    check("add_we", {28'h0, reg_we}, 32'hF);
    check("add_wd", reg_wd, 32'h12345678);
    check("add_wr", {27'h0, reg_wr}, 32'd3);
    check("add_fwd", {31'h0, fwd_valid}, 32'h1);
    step();
    check("add_retired", retired, 32'd1);

    load("lb",  LB,  32'h1003, 32'h80FF0011, 2, 4'hF, 32'hFFFFFF80, 1'b1);
    load("lbu", LBU, 32'h1003, 32'h80FF0011, 2, 4'hF, 32'h00000080, 1'b1);
    load("lh",  LH,  32'h1002, 32'h80011234, 1, 4'hF, 32'hFFFF8001, 1'b1);
    load("lhu", LHU, 32'h1002, 32'h80011234, 0, 4'hF, 32'h00008001, 1'b1);
    load("lw",  LW,  32'h1001, 32'h80011234, 1, 4'hF, 32'h80011234, 1'b1);
`ifdef WB_UNALIGNED_EN
    load("lwl", LWL, 32'h1001, 32'hAABBCCDD, 1, 4'b1100, 32'hCCDD0000, 1'b0);
    load("lwr", LWR, 32'h1002, 32'hAABBCCDD, 0, 4'b0011, 32'h0000AABB, 1'b0);
`else
    load("lwl", LWL, 32'h1001, 32'hAABBCCDD, 1, 4'b0000, 32'h0, 1'b0);
    load("lwr", LWR, 32'h1002, 32'hAABBCCDD, 0, 4'b0000, 32'h0, 1'b0);
`endif
    check("loads_retired", retired, 32'd8);

    // r0 destination retires without writing
    r_before = retired;
    issue(NONE, 1'b1, 5'd0, 32'hFFFFFFFF);
    check("r0_we", {28'h0, reg_we}, 32'h0);
    check("r0_fwd", {31'h0, fwd_valid}, 32'h0);
    step();
    check("r0_retired", retired, r_before + 32'd1);

    // back-to-back burst with data always ready (dm_data_ok also high while EMPTY/HOLD)
    dm_rdata   = 32'h11223344;
    dm_data_ok = 1'b1;
    mem_valid  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      mem_op  = b_op[i];
      mem_wen = b_wen[i];
      mem_wr  = b_wr[i];
      mem_res = b_res[i];
      mem_pc  = next_pc;
      next_pc = next_pc + 4;
      step();
    end
    mem_valid = 1'b0;
    step();
    dm_data_ok = 1'b0;
    step();
    check("burst_retired", retired, r_before + 32'd1 + NB);

    // reset while a load waits: dropped, no write, counter back to reset value
    issue(LW, 1'b1, 5'd12, 32'h3000);
    check("rw_busy", {31'h0, wb_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rw_we", {28'h0, reg_we}, 32'h0);
    check("rw_busy_rst", {31'h0, wb_busy}, 32'h0);
    check("rw_retired", retired, 32'h0);
    step();
    rst_n = 1'b1;
    dm_rdata   = 32'h99999999;
    dm_data_ok = 1'b1;
    step();
    check("rw_no_write", {28'h0, reg_we}, 32'h0);
    step();
    check("rw_not_counted", retired, 32'h0);
    dm_data_ok = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage feeding the byte-enabled register file. Accepts one instruction per handshake from the memory stage, waits for load data from data memory when needed, aligns and extends it, and drives the register file's byte write enables, write address and write data. Also exposes a bypass port for decode and a retired-instruction counter.

## Interface
- Parameters:
- CNT_W, 32, width of retired-instruction counter
- Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_valid  in  1  memory stage presents an instruction
- mem_ready  out  1  stage accepts this cycle; transfer when mem_valid && mem_ready
- mem_pc  in  32  instruction PC
- mem_op  in  3  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7
- mem_wen  in  1  instruction writes a GPR
- mem_wr  in  5  destination register
- mem_res  in  32  ALU result (non-load) or byte address (load)
- dm_rdata  in  32  data memory read word, little-endian byte lanes
- dm_data_ok  in  1  dm_rdata valid this cycle
- reg_we  out  4  per-byte write enables to register file
- reg_wr  out  5  write address
- reg_wd  out  32  write data, already lane-positioned
- fwd_valid  out  1  full-word result available for bypass
- fwd_wr  out  5  bypass register
- fwd_wd  out  32  bypass data
- wb_busy  out  1  holds a load awaiting data (decode must stall on match)
- wb_pc  out  32  PC of held instruction
- retired  out  CNT_W  committed instruction count

## Operation
- States: EMPTY, HOLD (non-load captured), WAIT (load captured, no data yet).
- EMPTY: capture -> HOLD if mem_op==NONE, else WAIT.
- HOLD: commits this cycle; capture -> HOLD/WAIT per new op, else -> EMPTY.
- WAIT: commits in cycle with dm_data_ok=1, then as HOLD; without dm_data_ok stays WAIT.
- mem_ready = EMPTY || HOLD || (WAIT && dm_data_ok).
- dm_data_ok outside WAIT is ignored.
- Commit cycle: reg_we/reg_wr/reg_wd valid; otherwise reg_we=0000. If !wen or wr==0, reg_we=0000 (still retired).
- a = mem_res[1:0]. LB/LBU: byte a, sign/zero extend, we=1111. LH/LHU: halfword a[1], a[0] ignored, we=1111. LW: a ignored, we=1111. NONE: wd=mem_res, we=1111.
- LWL: a=0 we=1000 wd=rdata<<24; a=1 1100 <<16; a=2 1110 <<8; a=3 1111 rdata.
- LWR: a=0 we=1111 rdata; a=1 0111 >>8; a=2 0011 >>16; a=3 0001 >>24.
- Bypass: fwd_valid=1 only in commit cycle with reg_we==1111 and wr!=0; fwd_wr/fwd_wd mirror reg_wr/reg_wd.
- wb_busy=1 in WAIT (including the commit cycle); partial writes (LWL/LWR) never forwarded.
- retired increments by 1 per commit, wraps at 2^CNT_W.

## Timing
- Reset: state EMPTY, reg_we=0000, reg_wr=0, reg_wd=0, fwd_valid=0, wb_busy=0, wb_pc=0, retired=0; mem_ready=1.
- Non-load: captured at edge N, committed in cycle N+1 (write lands at edge N+1).
- Load: earliest commit in cycle after capture; latency = dm_data_ok arrival.
- Back-to-back: full throughput, one commit per cycle when data is ready.
- Reset asserted in WAIT: load dropped, no write, not counted.

## Configuration
- WB_UNALIGNED_EN defined: LWL/LWR as above.
- Not defined: LWL/LWR still wait for dm_data_ok, commit with reg_we=0000, fwd_valid=0, retired increments.

## Structure
- Shared package: mem_op encodings, state enum, byte-enable constants.
- One sub-module: wb_load_align (combinational; op, a, rdata, res -> we, wd).

## Test plan
- Reset, ADD-type op wr=3 res=0x12345678 -> next cycle reg_we=1111, reg_wd=0x12345678, fwd_valid=1, retired=1.
- LB addr=...3, rdata=0x80FF0011, data_ok 2 cycles late -> mem_ready=0 while waiting, then wd=0xFFFFFF80; LBU same -> 0x00000080.
- LH addr=...2, rdata=0x8001_1234 -> wd=0xFFFF8001; LHU -> 0x00008001.
- WB_UNALIGNED_EN: LWL a=1 rdata=0xAABBCCDD -> we=1100, wd=0xCCDD0000, fwd_valid=0; LWR a=2 -> we=0011, wd=0x0000AABB.
- Write to wr=0 -> reg_we=0000, fwd_valid=0, retired increments.
- rst_n low during WAIT -> outputs to reset values, no write, retired unchanged.
